// File: rtl/traffic_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_ctrl_pkg                                                           |
// | Shared types and helpers for the multi-phase traffic-light controller.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package traffic_ctrl_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        WALK    = 2'd3
    } state_t;

    localparam int TICK_W_DEFAULT = 8;

    typedef logic [TICK_W_DEFAULT-1:0] tick_t;

    // Phase index width; a single-bit floor keeps degenerate counts legal.
    function automatic int phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_prescaler                                                             |
// | Divides the clock into timing ticks; restart realigns the tick phase.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = (r_count == c_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (restart || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_ctrl_multi                                                         |
// | Round-robin, demand-actuated N-phase signal controller with walk interval. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module traffic_ctrl_multi
    import traffic_ctrl_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int PRESCALE   = 4,
    parameter int TMR_W      = TICK_W_DEFAULT,
    parameter int T_GMIN     = 3,
    parameter int T_GMAX     = 6,
    parameter int T_Y        = 2,
    parameter int T_ALLRED   = 1,
    parameter int T_WALK     = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                clr,
    input  logic [NUM_PHASES-1:0]               req,
    input  logic                                ped_req,
    output logic [NUM_PHASES-1:0]               green,
    output logic [NUM_PHASES-1:0]               yellow,
    output logic [NUM_PHASES-1:0]               red,
    output logic                                walk,
    output logic [phase_w(NUM_PHASES)-1:0]      phase_idx,
    output logic                                busy_ped
);

    localparam int PHASE_W = phase_w(NUM_PHASES);

    localparam logic [TMR_W-1:0]   c_allred_last = TMR_W'(T_ALLRED - 1);
    localparam logic [TMR_W-1:0]   c_gmin_last   = TMR_W'(T_GMIN - 1);
    localparam logic [TMR_W-1:0]   c_gmax_last   = TMR_W'(T_GMAX - 1);
    localparam logic [TMR_W-1:0]   c_y_last      = TMR_W'(T_Y - 1);
    localparam logic [TMR_W-1:0]   c_walk_last   = TMR_W'(T_WALK - 1);
    localparam logic [PHASE_W-1:0] c_phase_last  = PHASE_W'(NUM_PHASES - 1);

    state_t                r_state, w_state_nxt;
    logic [PHASE_W-1:0]    r_phase, w_phase_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [NUM_PHASES-1:0] r_req_lat;
    logic                  r_ped_lat;
    logic [NUM_PHASES-1:0] w_own_mask, w_req_clr, w_green_nxt, w_yellow_nxt;
    logic                  w_tick, w_change, w_restart, w_enter_green, w_enter_walk;
    logic                  w_other_demand, w_green_done;

    // Scan starts just after the current phase, so it is its own last candidate.
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] cur,
                                                      input logic [NUM_PHASES-1:0] lat);
        logic [PHASE_W-1:0] cand;
        logic [PHASE_W-1:0] sel;
        logic               found;
        cand  = cur;
        sel   = (cur == c_phase_last) ? '0 : cur + 1'b1;
        found = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            cand = (cand == c_phase_last) ? '0 : cand + 1'b1;
            if (!found && lat[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .restart  (w_restart),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_own_mask     = NUM_PHASES'(1) << r_phase;
        w_other_demand = |(r_req_lat & ~w_own_mask);
        w_green_done   = ((r_timer >= c_gmin_last) && !req[r_phase]
                          && (w_other_demand || r_ped_lat))
                         || (r_timer == c_gmax_last);
        if (w_tick) begin
            case (r_state)
                ALL_RED: if (r_timer == c_allred_last) begin
                    w_state_nxt = GREEN;
                    w_phase_nxt = next_phase(r_phase, r_req_lat);
                end
                GREEN:   if (w_green_done) w_state_nxt = YELLOW;
                YELLOW:  if (r_timer == c_y_last) w_state_nxt = r_ped_lat ? WALK : ALL_RED;
                WALK:    if (r_timer == c_walk_last) w_state_nxt = ALL_RED;
                default: w_state_nxt = ALL_RED;
            endcase
        end
    end

    assign w_change      = (w_state_nxt != r_state);
    assign w_restart     = clr || w_change;
    assign w_enter_green = w_change && (w_state_nxt == GREEN);
    assign w_enter_walk  = w_change && (w_state_nxt == WALK);
    assign w_req_clr     = w_enter_green ? (NUM_PHASES'(1) << w_phase_nxt) : '0;
    assign w_green_nxt   = (w_state_nxt == GREEN)  ? (NUM_PHASES'(1) << w_phase_nxt) : '0;
    assign w_yellow_nxt  = (w_state_nxt == YELLOW) ? (NUM_PHASES'(1) << w_phase_nxt) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ALL_RED;
        end else if (clr) begin
            r_state <= ALL_RED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lamps are registered from the next-state values so they switch with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= c_phase_last;
            r_timer   <= '0;
            r_req_lat <= '0;
            r_ped_lat <= 1'b0;
            green     <= '0;
            yellow    <= '0;
            red       <= '1;
            walk      <= 1'b0;
        end else if (clr) begin
            r_phase   <= c_phase_last;
            r_timer   <= '0;
            r_req_lat <= '0;
            r_ped_lat <= 1'b0;
            green     <= '0;
            yellow    <= '0;
            red       <= '1;
            walk      <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            if (w_change) begin
                r_timer <= '0;
            end else if (w_tick && (r_timer != '1)) begin
                r_timer <= r_timer + 1'b1;
            end
            r_req_lat <= (r_req_lat | req) & ~w_req_clr;
            r_ped_lat <= (r_ped_lat | ped_req) & ~w_enter_walk;
            green     <= w_green_nxt;
            yellow    <= w_yellow_nxt;
            red       <= ~(w_green_nxt | w_yellow_nxt);
            walk      <= (w_state_nxt == WALK);
        end
    end

    assign phase_idx = r_phase;
    assign busy_ped  = r_ped_lat;

endmodule
`default_nettype wire

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
Parametrised multi-phase traffic-light controller, successor to the fixed three-counter light sequencer. N phases served round-robin, each green → yellow → all-red. Green is demand-actuated: a minimum time, extended while the own phase is demanded, capped at a maximum. Adds a latched pedestrian walk interval and a shared tick prescaler. Sits between the intersection sensor inputs and the lamp drivers.

Parameters:
NUM_PHASES, 4, number of signal phases (2..8)
PRESCALE, 4, clock cycles per timing tick (≥1)
TMR_W, 8, width of the phase tick timer
T_GMIN, 3, minimum green, in ticks
T_GMAX, 6, maximum green, in ticks (≥T_GMIN)
T_Y, 2, yellow, in ticks
T_ALLRED, 1, all-red clearance, in ticks
T_WALK, 4, pedestrian walk, in ticks

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; same effect as reset
req  in  NUM_PHASES  vehicle detector per phase, level
ped_req  in  1  pedestrian push-button, level
green  out  NUM_PHASES  green lamp per phase
yellow  out  NUM_PHASES  yellow lamp per phase
red  out  NUM_PHASES  red lamp per phase
walk  out  1  pedestrian walk lamp
phase_idx  out  clog2(NUM_PHASES)  current or last-served phase
busy_ped  out  1  pedestrian request pending

Behaviour:
- States: ALL_RED, GREEN, YELLOW, WALK.
- Reset or clr: state=ALL_RED, phase_idx=NUM_PHASES-1, prescaler=0, timer=0, req/ped latches=0. Outputs: red=all 1, green=0, yellow=0, walk=0, busy_ped=0.
- Prescaler counts 0..PRESCALE-1. It emits a tick when the count is PRESCALE-1. It restarts at 0 on every state change, so each state lasts exactly T×PRESCALE cycles.
- Timer counts ticks in the current state and clears on state change. Its width is TMR_W; it saturates and never wraps.
- Lamp outputs are registered and change in the same cycle as the state register.
  - In GREEN, only green[phase_idx] is set; all other phases show red.
  - In YELLOW, only yellow[phase_idx] is set.
  - In ALL_RED and WALK, every red bit is 1.
  - walk=1 only in WALK.
- Exactly one of green/yellow/red is 1 per phase in every cycle.
- Request latches:
  - Bit k sets while req[k]=1.
  - Bit k clears in the cycle GREEN for phase k is entered; clear wins over a simultaneous set.
  - The ped latch sets on ped_req and clears on entry to WALK, again with clear winning.
  - busy_ped = ped latch.
- ALL_RED → GREEN on the tick with timer=T_ALLRED-1.
  - New phase = first latched phase in round-robin order starting at phase_idx+1 (mod N).
  - If no latch is set, new phase = phase_idx+1 (mod N), i.e. a free-running cycle.
- GREEN → YELLOW on the tick where either condition holds:
  - timer ≥ T_GMIN-1, req[phase_idx] is low, and some other latch or the ped latch is set; or
  - timer = T_GMAX-1.
  - If no other demand exists, green holds past T_GMIN only until T_GMAX.
- YELLOW → WALK on the tick with timer=T_Y-1 if the ped latch is set; otherwise YELLOW → ALL_RED.
- WALK → ALL_RED on the tick with timer=T_WALK-1.
- phase_idx updates only on ALL_RED→GREEN.
- Reset asserted mid-state returns to the reset values asynchronously. clr mid-state does the same on the next edge.

Decomposition:
- Package traffic_ctrl_pkg: state enum (ALL_RED, GREEN, YELLOW, WALK), PHASE_W = clog2(NUM_PHASES) helper, tick-count typedef.
- Sub-module tick_prescaler: counter with restart input and tick output, parametrised by PRESCALE.
- Round-robin next-phase selection stays an inline function in the top level.

Test Plan:
1. Defaults, release reset, no requests → red=4'b1111 for 4 cycles, then green[0]=1 for 24 cycles (GMAX=6 ticks, no other demand), yellow[0] for 8, all-red 4, then green[1].
2. req[2] pulsed during phase-0 green at tick 0, req[0] held low → phase 0 leaves green after exactly 12 cycles (GMIN). Next green is phase 2 and phase 1 is skipped. Latch bit 2 clears on entry.
3. req[0] held high during phase-0 green with req[1] pending → green lasts 24 cycles (GMAX cap), then phase 1.
4. ped_req pulsed 1 cycle during green → busy_ped=1. After yellow, walk=1 with all red for 16 cycles, then all-red for 4 cycles, then the next phase.
5. clr asserted mid-yellow → next cycle red=all 1, yellow=0, phase_idx=3, latches 0. Sequence restarts as in scenario 1.
6. Parameters NUM_PHASES=2, PRESCALE=1, no requests → phases alternate 0,1,0. Round-robin wraps and each green lasts exactly 6 cycles.
